// File: rtl/uart_tx_arb.sv
// Round-robin arbiter letting NUM_REQ requesters share a single uart_tx.
// Optional WAIT_BUSY abort timer is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arb #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     done,
    output logic                   tx_send,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
    output logic                   timeout_err
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LAUNCH    = 3'd1;
    localparam logic [2:0] WAIT_BUSY = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [IdxW-1:0] win_q, win_d;
    logic [IdxW-1:0] last_q, last_d;
    logic [7:0]      data_q, data_d;
    logic [IdxW-1:0] pick_idx;
    logic [7:0]      pick_data;
    logic            pick_vld;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            to_q, to_d;
    assign timeout_err = to_q;
`else
    assign timeout_err = 1'b0;
`endif

    // Search starts one past the last winner and wraps; first set bit wins.
    always_comb begin
        int cand;
        cand      = 0;
        pick_vld  = 1'b0;
        pick_idx  = last_q;
        pick_data = 8'h00;
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            cand = (int'(last_q) + i) % int'(NUM_REQ);
            if (!pick_vld && req[IdxW'(cand)]) begin
                pick_vld  = 1'b1;
                pick_idx  = IdxW'(cand);
                pick_data = req_data[8*cand +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        last_d  = last_q;
        data_d  = data_q;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        to_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_vld && !tx_busy) begin
                    state_d = LAUNCH;
                    win_d   = pick_idx;
                    data_d  = pick_data;
                end
            end
            LAUNCH: begin
                state_d = WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = IDLE;
                    last_d  = win_q;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                last_d  = win_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // gnt/done decode straight from state so reset clears them asynchronously.
    always_comb begin
        gnt  = '0;
        done = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (win_q == IdxW'(i)) begin
                gnt[i]  = (state_q != IDLE);
                done[i] = (state_q == DONE);
            end
        end
    end

    assign tx_send = (state_q == LAUNCH);
    assign tx_data = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            win_q   <= '0;
            last_q  <= IdxW'(NUM_REQ - 1);
            data_q  <= 8'h00;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            last_q  <= last_d;
            data_q  <= data_d;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            to_q    <= to_d;
`endif
        end
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL provide parameter NUM_REQ, default 4, number of requesters sharing one uart_tx.
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 16, cycles allowed in WAIT_BUSY before abort (used only when UART_ARB_TIMEOUT_EN is defined).
REQ-003 SHALL provide port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL provide port req  input  NUM_REQ  per-requester transmit request, held high until that requester's done.
REQ-006 SHALL provide port req_data  input  8*NUM_REQ  byte for requester i on bits [8i+7:8i].
REQ-007 SHALL provide port gnt  output  NUM_REQ  one-hot grant; high from LAUNCH through DONE inclusive.
REQ-008 SHALL provide port done  output  NUM_REQ  one-cycle pulse to the granted requester when its byte has left the line.
REQ-009 SHALL provide port tx_send  output  1  one-cycle start strobe to uart_tx send.
REQ-010 SHALL provide port tx_data  output  8  byte to uart_tx data_in, stable from LAUNCH to DONE.
REQ-011 SHALL provide port tx_busy  input  1  uart_tx busy.
REQ-012 SHALL provide port timeout_err  output  1  one-cycle pulse on WAIT_BUSY abort.

Function
REQ-013 SHALL implement FSM states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, DONE.
REQ-014 SHALL, in IDLE with any req bit high and tx_busy=0, select a winner and enter LAUNCH at the next edge.
REQ-015 SHALL stay in IDLE while tx_busy=1, even with requests pending.
REQ-016 SHALL pick the winner by round-robin: search from (last_winner+1) mod NUM_REQ upward, wrapping, first set bit wins.
REQ-017 SHALL latch the winner's req_data into tx_data and set gnt on the IDLE->LAUNCH edge; req_data changes after that edge SHALL be ignored.
REQ-018 SHALL drive tx_send=1 in LAUNCH only, for exactly one cycle, then enter WAIT_BUSY.
REQ-019 SHALL move WAIT_BUSY->WAIT_DONE on the first cycle tx_busy=1.
REQ-020 SHALL move WAIT_DONE->DONE on the first cycle tx_busy=0.
REQ-021 SHALL, in DONE, pulse done[winner] for one cycle, update last_winner, and return to IDLE; grant-to-grant spacing is at least one IDLE cycle.
REQ-022 SHALL NOT abort a transfer when the granted req drops mid-transfer; done still pulses.
REQ-023 SHALL ignore req bits of non-granted requesters until IDLE; arbitration is re-evaluated only in IDLE.
REQ-024 SHALL keep tx_send, done, timeout_err low in all states other than those listed above.

Reset
REQ-025 SHALL, on rst_n low, immediately enter IDLE with gnt=0, done=0, tx_send=0, tx_data=8'h00, timeout_err=0, last_winner=NUM_REQ-1 (so requester 0 has first priority).
REQ-026 SHALL, on reset mid-transfer, drop the transfer without a done pulse; the outputs take their reset values asynchronously.
REQ-027 SHALL leave reset synchronously on the first clk edge after rst_n rises.

Configuration
REQ-028 SHALL, with UART_ARB_TIMEOUT_EN defined, count cycles in WAIT_BUSY and, when the count reaches TIMEOUT_CYCLES, pulse timeout_err, clear gnt, skip done, update last_winner, and return to IDLE.
REQ-029 SHALL, without UART_ARB_TIMEOUT_EN, wait in WAIT_BUSY indefinitely, omit the counter, and tie timeout_err to 0.

Verification
REQ-030 Single request: req=4'b0100, byte 8'h0B, tx_busy high 3 cycles after tx_send -> gnt=4'b0100, one tx_send pulse, tx_data=8'h0B, done[2] one cycle after tx_busy falls.
REQ-031 Round-robin: req=4'b1111 held across four transfers after reset -> grant order 0,1,2,3, then 0 again.
REQ-032 Busy at idle: tx_busy=1 with req=4'b0001 for 5 cycles -> no tx_send; launch on the cycle after tx_busy=0.
REQ-033 Reset mid-transfer: rst_n low in WAIT_DONE -> gnt=0, tx_send=0, no done; after release req=4'b0010 -> requester 1 granted.
REQ-034 Timeout (macro defined, TIMEOUT_CYCLES=16): tx_busy held 0 -> timeout_err pulses 16 cycles after entering WAIT_BUSY, no done, FSM returns to IDLE.
REQ-035 Data hold: req_data changed during WAIT_DONE -> tx_data holds the latched byte until DONE.
